// File: rtl/blake_pkg.sv
// Shared constants for the Blake-512 message scheduler: round constants,
// the sigma permutation table and datapath widths.
package blake_pkg;

    localparam int WORD_W     = 64;
    localparam int LANES      = 4;
    localparam int STEP_W     = 5;
    localparam int SIGMA_ROWS = 10;

    localparam logic [0:15][WORD_W-1:0] BLAKE_C = '{
        64'h243F6A8885A308D3, 64'h13198A2E03707344,
        64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
        64'h452821E638D01377, 64'hBE5466CF34E90C6C,
        64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
        64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC,
        64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
        64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7,
        64'h0801F2E2858EFC16, 64'h636920D871574E69
    };

    localparam logic [0:SIGMA_ROWS-1][0:15][3:0] SIGMA = '{
        '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,  4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
        '{4'd14, 4'd10, 4'd4,  4'd8,  4'd9,  4'd15, 4'd13, 4'd6,  4'd1,  4'd12, 4'd0,  4'd2,  4'd11, 4'd7,  4'd5,  4'd3},
        '{4'd11, 4'd8,  4'd12, 4'd0,  4'd5,  4'd2,  4'd15, 4'd13, 4'd10, 4'd14, 4'd3,  4'd6,  4'd7,  4'd1,  4'd9,  4'd4},
        '{4'd7,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd11, 4'd14, 4'd2,  4'd6,  4'd5,  4'd10, 4'd4,  4'd0,  4'd15, 4'd8},
        '{4'd9,  4'd0,  4'd5,  4'd7,  4'd2,  4'd4,  4'd10, 4'd15, 4'd14, 4'd1,  4'd11, 4'd12, 4'd6,  4'd8,  4'd3,  4'd13},
        '{4'd2,  4'd12, 4'd6,  4'd10, 4'd0,  4'd11, 4'd8,  4'd3,  4'd4,  4'd13, 4'd7,  4'd5,  4'd15, 4'd14, 4'd1,  4'd9},
        '{4'd12, 4'd5,  4'd1,  4'd15, 4'd14, 4'd13, 4'd4,  4'd10, 4'd0,  4'd7,  4'd6,  4'd3,  4'd9,  4'd2,  4'd8,  4'd11},
        '{4'd13, 4'd11, 4'd7,  4'd14, 4'd12, 4'd1,  4'd3,  4'd9,  4'd5,  4'd0,  4'd15, 4'd4,  4'd8,  4'd6,  4'd2,  4'd10},
        '{4'd6,  4'd15, 4'd14, 4'd9,  4'd11, 4'd3,  4'd0,  4'd8,  4'd12, 4'd2,  4'd13, 4'd7,  4'd1,  4'd4,  4'd10, 4'd5},
        '{4'd10, 4'd2,  4'd8,  4'd4,  4'd7,  4'd6,  4'd1,  4'd5,  4'd15, 4'd11, 4'd9,  4'd14, 4'd3,  4'd12, 4'd13, 4'd0}
    };

    // Rounds 10..15 wrap back onto sigma rows 0..5.
    function automatic logic [3:0] sigma_row(input logic [3:0] round);
        return (round >= 4'd10) ? (round - 4'd10) : round;
    endfunction

endpackage

// File: rtl/blake_sigma_rom.sv
// Sigma lookup for one half-round: message word indices for all four G lanes.
module blake_sigma_rom
    import blake_pkg::*;
(
    input  logic                  [3:0] row,
    input  logic                        diag,
    output logic [LANES-1:0]      [3:0] idx_even,
    output logic [LANES-1:0]      [3:0] idx_odd
);

    // Lane k uses G index j = k + 4*diag, so positions 2j / 2j+1 are {diag, k, 0/1}.
    always_comb begin
        idx_even = '0;
        idx_odd  = '0;
        for (int k = 0; k < LANES; k++) begin
            idx_even[k] = SIGMA[row][{diag, 2'(k), 1'b0}];
            idx_odd[k]  = SIGMA[row][{diag, 2'(k), 1'b1}];
        end
    end

endmodule

// File: rtl/blake_msg_sched.sv
// Blake-512 message/round sequencer: latches a message block and presents the
// sigma-permuted, constant-XORed word pairs for each half-round.
module blake_msg_sched
    import blake_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    init_round,
    input  logic                    round_ing,
    input  logic [1023:0]           msg_in,
    output logic                    count_done,
    output logic [3:0]              round_idx,
    output logic                    diag,
    output logic [LANES*WORD_W-1:0] mc_a,
    output logic [LANES*WORD_W-1:0] mc_b,
    output logic                    mc_valid
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * ROUNDS - 1);

    logic [0:15][WORD_W-1:0]   msg_q;
    logic [STEP_W-1:0]         step;
    logic [STEP_W-1:0]         step_inc;
    logic                      count_done_q;
    logic [LANES-1:0][3:0]     idx_even;
    logic [LANES-1:0][3:0]     idx_odd;

    assign step_inc   = step + STEP_W'(1);
    assign round_idx  = step[4:1];
    assign diag       = step[0];
    assign count_done = count_done_q;
    assign mc_valid   = round_ing;

    // A fresh block always restarts from step 0; the final step is held, never wrapped.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            step         <= '0;
            msg_q        <= '0;
            count_done_q <= 1'b0;
        end else if (init_round) begin
            msg_q        <= msg_in;
            step         <= '0;
            count_done_q <= 1'b0;
        end else if (round_ing) begin
            if (step < LAST_STEP) begin
                step         <= step_inc;
                count_done_q <= (step_inc == LAST_STEP);
            end else begin
                count_done_q <= 1'b0;
            end
        end
    end

    blake_sigma_rom u_sigma_rom (
        .row      (sigma_row(round_idx)),
        .diag     (diag),
        .idx_even (idx_even),
        .idx_odd  (idx_odd)
    );

    always_comb begin
        mc_a = '0;
        mc_b = '0;
        for (int k = 0; k < LANES; k++) begin
            mc_a[WORD_W*k +: WORD_W] = msg_q[idx_even[k]] ^ BLAKE_C[idx_odd[k]];
            mc_b[WORD_W*k +: WORD_W] = msg_q[idx_odd[k]]  ^ BLAKE_C[idx_even[k]];
        end
    end

endmodule

// File: tb/tb_blake_msg_sched.sv
// Scoreboard bench for blake_msg_sched: the driver queues hand-computed
// expectations, a negedge monitor pops and compares whenever mc_valid is high.
module tb_blake_msg_sched;

    logic           clk = 1'b0;
    logic           rstb = 1'b0;
    logic           init_round = 1'b0;
    logic           round_ing = 1'b0;
    logic [1023:0]  msg_in = '0;
    logic           count_done;
    logic [3:0]     round_idx;
    logic           diag;
    logic [255:0]   mc_a;
    logic [255:0]   mc_b;
    logic           mc_valid;

    typedef struct {
        string       tag;
        logic        cd;
        logic [3:0]  ridx;
        logic        dg;
        bit          chk;
        int          lane;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic [1023:0] msg_a;
    logic [1023:0] msg_b;
    logic [1023:0] msg_z;

    blake_msg_sched #(.ROUNDS(16)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .init_round (init_round),
        .round_ing  (round_ing),
        .msg_in     (msg_in),
        .count_done (count_done),
        .round_idx  (round_idx),
        .diag       (diag),
        .mc_a       (mc_a),
        .mc_b       (mc_b),
        .mc_valid   (mc_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [1023:0] build_msg(input logic [63:0] base);
        logic [1023:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[1023-64*i -: 64] = base + 64'(i);
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    // One cycle of stimulus; while round_ing is driven high the expected view
    // of that same cycle is queued for the monitor.
    task automatic applyStimulus(input logic rst_v, input logic init_v, input logic ring_v,
                                 input logic [1023:0] msg_v, input int exp_step, input logic exp_cd,
                                 input string tag, input bit chk, input int lane,
                                 input logic [63:0] ea, input logic [63:0] eb);
        exp_t       e;
        logic [4:0] s;
        @(posedge clk);
        #1;
        rstb       = rst_v;
        init_round = init_v;
        round_ing  = ring_v;
        msg_in     = msg_v;
        if (ring_v) begin
            s      = 5'(exp_step);
            e.tag  = tag;
            e.cd   = exp_cd;
            e.ridx = s[4:1];
            e.dg   = s[0];
            e.chk  = chk;
            e.lane = lane;
            e.a    = ea;
            e.b    = eb;
            sb_q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mc_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_valid: got mc_valid 1 with nothing queued, required 0");
                end else begin
                    e = sb_q.pop_front();
                    checkOutput({e.tag, "_count_done"}, 64'(count_done), 64'(e.cd));
                    checkOutput({e.tag, "_round_idx"}, 64'(round_idx), 64'(e.ridx));
                    checkOutput({e.tag, "_diag"}, 64'(diag), 64'(e.dg));
                    if (e.chk) begin
                        checkOutput($sformatf("%s_mc_a_lane%0d", e.tag, e.lane), mc_a[64*e.lane +: 64], e.a);
                        checkOutput($sformatf("%s_mc_b_lane%0d", e.tag, e.lane), mc_b[64*e.lane +: 64], e.b);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        bit          chk;
        int          lane;
        int          st;
        logic [63:0] ea;
        logic [63:0] eb;

        msg_a = build_msg(64'h0);
        msg_b = build_msg(64'h100);
        msg_z = '0;

        // Reset beats init: the block offered during reset must not be captured.
        applyStimulus(1'b0, 1'b0, 1'b0, msg_z, 0, 1'b0, "", 1'b0, 0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, msg_a, 0, 1'b0, "", 1'b0, 0, '0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, msg_z, 0, 1'b0, "reset", 1'b1, 0,
                      64'h13198A2E03707344, 64'h243F6A8885A308D3);
        applyStimulus(1'b1, 1'b0, 1'b0, msg_z, 0, 1'b0, "", 1'b0, 0, '0, '0);

        // Full run with m_i = i.
        applyStimulus(1'b1, 1'b1, 1'b0, msg_a, 0, 1'b0, "", 1'b0, 0, '0, '0);
        for (int c = 1; c <= 34; c++) begin
            chk = 1'b1; lane = 0; ea = '0; eb = '0;
            case (c)
                1:  begin ea = 64'h13198A2E03707344; eb = 64'h243F6A8885A308D2; end
                2:  begin ea = 64'hD1310BA698DFB5A4; eb = 64'h9216D5D98979FB12; end
                3:  begin ea = 64'h2FFD72DBD01ADFB9; eb = 64'h0801F2E2858EFC1C; end
                21: begin ea = 64'h13198A2E03707344; eb = 64'h243F6A8885A308D2; end
                32: begin ea = 64'h24A19947B3916CF3; eb = 64'h452821E638D0137A; end
                33: begin lane = 3; ea = 64'hD1310BA698DFB5AD; eb = 64'h13198A2E0370734D; end
                default: chk = 1'b0;
            endcase
            st = (c - 1 > 31) ? 31 : c - 1;
            applyStimulus(1'b1, 1'b0, 1'b1, msg_z, st, (c == 32), $sformatf("full_c%0d", c), chk, lane, ea, eb);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, msg_z, 0, 1'b0, "", 1'b0, 0, '0, '0);

        // Restart mid-run at cycle 10 with a new block.
        applyStimulus(1'b1, 1'b1, 1'b0, msg_a, 0, 1'b0, "", 1'b0, 0, '0, '0);
        for (int c = 1; c <= 43; c++) begin
            chk = 1'b1; lane = 0; ea = '0; eb = '0;
            case (c)
                10: begin ea = 64'h13198A2E0370734A; eb = 64'h0801F2E2858EFC17; end
                11: begin ea = 64'h13198A2E03707244; eb = 64'h243F6A8885A309D2; end
                default: chk = 1'b0;
            endcase
            if (c <= 10) st = c - 1;
            else         st = (c - 11 > 31) ? 31 : c - 11;
            applyStimulus(1'b1, (c == 10), 1'b1, (c == 10) ? msg_b : msg_z, st, (c == 42),
                          $sformatf("restart_c%0d", c), chk, lane, ea, eb);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, msg_z, 0, 1'b0, "", 1'b0, 0, '0, '0);

        // One-cycle reset at cycle 5 of a run clears step and message.
        applyStimulus(1'b1, 1'b1, 1'b0, msg_a, 0, 1'b0, "", 1'b0, 0, '0, '0);
        for (int c = 1; c <= 38; c++) begin
            chk = 1'b1; lane = 0; ea = '0; eb = '0;
            case (c)
                6: begin ea = 64'h13198A2E03707344; eb = 64'h243F6A8885A308D3; end
                7: begin ea = 64'hD1310BA698DFB5AC; eb = 64'h9216D5D98979FB1B; end
                default: chk = 1'b0;
            endcase
            if (c <= 5) st = c - 1;
            else        st = (c - 6 > 31) ? 31 : c - 6;
            applyStimulus((c != 5), 1'b0, 1'b1, msg_z, st, (c == 37),
                          $sformatf("midreset_c%0d", c), chk, lane, ea, eb);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, msg_z, 0, 1'b0, "", 1'b0, 0, '0, '0);

        // A 3-cycle round_ing gap pushes count_done from cycle 32 to 35.
        applyStimulus(1'b1, 1'b1, 1'b0, msg_a, 0, 1'b0, "", 1'b0, 0, '0, '0);
        for (int c = 1; c <= 37; c++) begin
            chk = (c == 9); lane = 0;
            ea = 64'h0801F2E2858EFC1C; eb = 64'h2FFD72DBD01ADFB9;
            if (c < 6) st = c - 1;
            else       st = (c - 4 > 31) ? 31 : c - 4;
            applyStimulus(1'b1, 1'b0, !(c >= 6 && c <= 8), msg_z, st, (c == 35),
                          $sformatf("gap_c%0d", c), chk, lane, ea, eb);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, msg_z, 0, 1'b0, "", 1'b0, 0, '0, '0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("[TB] FAIL scoreboard_drain: got %0d unconsumed expectations, required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
